// File: rtl/aes_frame_tx.sv
// Byte-serial frame transmitter for key and plain-text blocks, with an independent
// 16-byte response collector that has an inter-byte timeout.
module aes_frame_tx #(
  parameter logic [7:0]  PAD_BYTE   = 8'h0A,
  parameter logic [31:0] RX_TIMEOUT = 32'd5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_req,
  input  logic [255:0] key_data,
  input  logic [1:0]   key_len,
  input  logic         plain_req,
  input  logic [127:0] plain_data,
  output logic         busy,
  output logic         frame_done,
  output logic         req_error,
  output logic [7:0]   tx_data,
  output logic         tx_flag,
  input  logic         tx_end,
  input  logic [7:0]   rx_data,
  input  logic         rx_flag,
  output logic [127:0] resp_data,
  output logic         resp_valid,
  output logic         resp_timeout
);
  localparam int unsigned DATA_W = 256;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SHR_W  = 120;
  localparam int unsigned TMR_W  = 32;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_END, DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_req_error;
  logic [7:0]          r_tx_data;
  logic                r_tx_flag;
  logic                r_is_key;
  logic [7:0]          r_mode;
  logic [DATA_W-1:0]   r_data;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_last;

  logic [IDX_W-1:0]    w_next_idx;
  logic [7:0]          w_next_byte;
  logic                w_take_data;

  logic [SHR_W-1:0]    r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [TMR_W-1:0]    r_timer;
  logic [BLK_W-1:0]    r_resp_data;
  logic                r_resp_valid;
  logic                r_resp_timeout;

  // Next byte of the frame: header characters, then payload popped from r_data, then pad.
  always_comb begin
    w_next_idx  = r_idx + 6'd1;
    w_next_byte = PAD_BYTE;
    w_take_data = 1'b0;
    if (w_next_idx == r_last) begin
      w_next_byte = PAD_BYTE;
    end else if (r_is_key && (w_next_idx < 6'd4)) begin
      case (w_next_idx[1:0])
        2'd1:    w_next_byte = 8'h65;
        2'd2:    w_next_byte = 8'h79;
        default: w_next_byte = r_mode;
      endcase
    end else if (!r_is_key && (w_next_idx < 6'd5)) begin
      case (w_next_idx[2:0])
        3'd1:    w_next_byte = 8'h6C;
        3'd2:    w_next_byte = 8'h61;
        3'd3:    w_next_byte = 8'h69;
        default: w_next_byte = 8'h6E;
      endcase
    end else begin
      w_next_byte = r_data[DATA_W-1 -: 8];
      w_take_data = 1'b1;
    end
  end

  // Transmit FSM; the first header byte is a constant, so it is issued straight from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_req_error  <= 1'b0;
      r_tx_data    <= '0;
      r_tx_flag    <= 1'b0;
      r_is_key     <= 1'b0;
      r_mode       <= '0;
      r_data       <= '0;
      r_idx        <= '0;
      r_last       <= '0;
    end else begin
      r_tx_flag    <= 1'b0;
      r_frame_done <= 1'b0;
      r_req_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (key_req) begin
            if (key_len == 2'd3) begin
              r_req_error <= 1'b1;
            end else begin
              r_is_key  <= 1'b1;
              r_mode    <= 8'h61 + {6'b0, key_len};
              r_data    <= key_data;
              r_last    <= 6'd20 + {1'b0, key_len, 3'b000};
              r_idx     <= '0;
              r_tx_data <= 8'h6B;
              r_tx_flag <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= SEND;
            end
          end else if (plain_req) begin
            r_is_key  <= 1'b0;
            r_mode    <= '0;
            r_data    <= {plain_data, {BLK_W{1'b0}}};
            r_last    <= 6'd21;
            r_idx     <= '0;
            r_tx_data <= 8'h70;
            r_tx_flag <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: r_state <= WAIT_END;
        WAIT_END: begin
          if (tx_end) begin
            if (r_idx == r_last) begin
              r_frame_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              r_tx_flag <= 1'b1;
              if (w_take_data) r_data <= r_data << 8;
              r_state   <= SEND;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Response collector; a timeout takes precedence over a coincident byte, which restarts the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= '0;
      r_cnt          <= '0;
      r_timer        <= '0;
      r_resp_data    <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
      if ((r_cnt != '0) && (r_timer == RX_TIMEOUT)) begin
        r_resp_timeout <= 1'b1;
        r_timer        <= '0;
        if (rx_flag) begin
          r_shift <= {{(SHR_W-8){1'b0}}, rx_data};
          r_cnt   <= 5'd1;
        end else begin
          r_shift <= '0;
          r_cnt   <= '0;
        end
      end else if (rx_flag) begin
        r_timer <= '0;
        if (r_cnt == 5'd15) begin
          r_resp_data  <= {r_shift, rx_data};
          r_resp_valid <= 1'b1;
          r_shift      <= '0;
          r_cnt        <= '0;
        end else begin
          r_shift <= {r_shift[SHR_W-9:0], rx_data};
          r_cnt   <= r_cnt + 5'd1;
        end
      end else if (r_cnt != '0) begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end

  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign req_error    = r_req_error;
  assign tx_data      = r_tx_data;
  assign tx_flag      = r_tx_flag;
  assign resp_data    = r_resp_data;
  assign resp_valid   = r_resp_valid;
  assign resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_aes_frame_tx.sv
// Directed bench for aes_frame_tx: frames, request handling, response collection and reset abort.
`timescale 1ns/1ps
module tb_aes_frame_tx;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_req = 1'b0;
  logic [255:0] key_data = '0;
  logic [1:0]   key_len = '0;
  logic         plain_req = 1'b0;
  logic [127:0] plain_data = '0;
  logic         busy, frame_done, req_error, tx_flag, resp_valid, resp_timeout;
  logic [7:0]   tx_data;
  logic         tx_end = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_flag = 1'b0;
  logic [127:0] resp_data;

  int checks = 0;
  int errors = 0;
  int tx_delay = 20;
  int tx_cnt = 0;
  int flag_cnt = 0;
  int done_cnt = 0;
  logic [7:0] txq[$];

  aes_frame_tx #(.PAD_BYTE(8'h0A), .RX_TIMEOUT(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .key_req(key_req), .key_data(key_data), .key_len(key_len),
    .plain_req(plain_req), .plain_data(plain_data), .busy(busy), .frame_done(frame_done),
    .req_error(req_error), .tx_data(tx_data), .tx_flag(tx_flag), .tx_end(tx_end),
    .rx_data(rx_data), .rx_flag(rx_flag), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  // Byte transmitter model: tx_end tx_delay cycles after each tx_flag.
  always @(negedge clk) begin
    tx_end = 1'b0;
    if (!rst_n) begin
      tx_cnt = 0;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) tx_end = 1'b1;
    end else if (tx_flag) begin
      tx_cnt = tx_delay - 1;
    end
  end

  always @(negedge clk) begin
    if (tx_flag) begin
      txq.push_back(tx_data);
      flag_cnt = flag_cnt + 1;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    @(negedge clk);
    rx_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_req = 1'b1;
    key_len = 2'd0;
    plain_req = 1'b1;
    rx_flag = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, frame_done, req_error, tx_flag, resp_valid, resp_timeout} !== 6'b0 ||
        tx_data !== 8'h00 || resp_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b flag=%b data=%h resp=%h rv=%b rt=%b, required all 0",
               busy, frame_done, req_error, tx_flag, tx_data, resp_data, resp_valid, resp_timeout);
    end
    key_req = 1'b0;
    plain_req = 1'b0;
    rx_flag = 1'b0;
  endtask

  task automatic test_plain();
    logic [7:0] exp[$];
    int s;
    bit ok;
    exp = {8'h70, 8'h6C, 8'h61, 8'h69, 8'h6E};
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h11 * i));
    exp.push_back(8'h0A);
    tx_delay = 20;
    s = txq.size();
    rst_n = 1'b1;
    plain_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    plain_req = 1'b1;
    @(negedge clk);
    plain_req = 1'b0;
    plain_data = '1;
    checks++;
    if (tx_flag !== 1'b1 || tx_data !== 8'h70 || busy !== 1'b1) begin
      errors++;
      $display("FAIL plain_first_byte: flag=%b data=%h busy=%b, required 1 70 1", tx_flag, tx_data, busy);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL plain_done_timeout: frame_done not seen, required within 2000 cycles");
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL plain_busy_in_done: busy=%b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h0A) begin
      errors++;
      $display("FAIL plain_after_done: done=%b busy=%b data=%h, required 0 0 0a", frame_done, busy, tx_data);
    end
    checks++;
    if (txq.size() - s !== 22) begin
      errors++;
      $display("FAIL plain_len: got %0d bytes, required 22", txq.size() - s);
    end
    for (int i = 0; i < 22 && s + i < txq.size(); i++) begin
      checks++;
      if (txq[s + i] !== exp[i]) begin
        errors++;
        $display("FAIL plain_byte%0d: got %h, required %h", i, txq[s + i], exp[i]);
      end
    end
  endtask

  task automatic test_key();
    logic [7:0] exp[$];
    logic [255:0] kd;
    int s;
    bit ok;
    for (int i = 0; i < 32; i++) kd[255 - 8 * i -: 8] = 8'(i);
    exp = {8'h6B, 8'h65, 8'h79, 8'h62};
    for (int i = 0; i < 24; i++) exp.push_back(8'(i));
    exp.push_back(8'h0A);
    tx_delay = 3;
    s = txq.size();
    key_data = kd;
    key_len = 2'd1;
    key_req = 1'b1;
    @(negedge clk);
    key_req = 1'b0;
    key_data = '1;
    key_len = 2'd2;
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL key_done_timeout: frame_done not seen, required within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (txq.size() - s !== 29) begin
      errors++;
      $display("FAIL key_len: got %0d bytes, required 29", txq.size() - s);
    end
    for (int i = 0; i < 29 && s + i < txq.size(); i++) begin
      checks++;
      if (txq[s + i] !== exp[i]) begin
        errors++;
        $display("FAIL key_byte%0d: got %h, required %h", i, txq[s + i], exp[i]);
      end
    end
  endtask

  task automatic test_invalid_and_priority();
    logic [7:0] exp[$];
    int f0, d0, s;
    bit ok;
    f0 = flag_cnt;
    key_len = 2'd3;
    key_req = 1'b1;
    @(negedge clk);
    key_req = 1'b0;
    checks++;
    if (req_error !== 1'b1 || busy !== 1'b0 || tx_flag !== 1'b0) begin
      errors++;
      $display("FAIL invalid_err: err=%b busy=%b flag=%b, required 1 0 0", req_error, busy, tx_flag);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (req_error !== 1'b0 || flag_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL invalid_quiet: err=%b flags=%0d, required 0 0", req_error, flag_cnt - f0);
    end
    exp = {8'h6B, 8'h65, 8'h79, 8'h61};
    for (int i = 0; i < 16; i++) begin
      key_data[255 - 8 * i -: 8] = 8'(8'h80 + i);
      exp.push_back(8'(8'h80 + i));
    end
    exp.push_back(8'h0A);
    s = txq.size();
    d0 = done_cnt;
    key_len = 2'd0;
    key_req = 1'b1;
    plain_req = 1'b1;
    @(negedge clk);
    key_req = 1'b0;
    plain_req = 1'b0;
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL prio_done_timeout: frame_done not seen, required within 1000 cycles");
    end
    repeat (100) @(negedge clk);
    checks++;
    if (txq.size() - s !== 21 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL prio_count: bytes=%0d frames=%0d, required 21 1", txq.size() - s, done_cnt - d0);
    end
    for (int i = 0; i < 21 && s + i < txq.size(); i++) begin
      checks++;
      if (txq[s + i] !== exp[i]) begin
        errors++;
        $display("FAIL prio_byte%0d: got %h, required %h", i, txq[s + i], exp[i]);
      end
    end
  endtask

  task automatic test_busy_drop();
    int s, d0;
    bit ok;
    for (int i = 0; i < 32; i++) key_data[255 - 8 * i -: 8] = 8'(8'hF0 ^ i);
    s = txq.size();
    d0 = done_cnt;
    key_len = 2'd2;
    key_req = 1'b1;
    @(negedge clk);
    key_req = 1'b0;
    key_data = '0;
    repeat (10) @(negedge clk);
    plain_data = 128'h1;
    plain_req = 1'b1;
    @(negedge clk);
    plain_req = 1'b0;
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_done_timeout: frame_done not seen, required within 1000 cycles");
    end
    repeat (100) @(negedge clk);
    checks++;
    if (txq.size() - s !== 37 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL busy_count: bytes=%0d frames=%0d, required 37 1", txq.size() - s, done_cnt - d0);
    end else begin
      checks++;
      if (txq[s] !== 8'h6B || txq[s + 3] !== 8'h63 || txq[s + 4] !== 8'hF0 ||
          txq[s + 35] !== 8'hEF || txq[s + 36] !== 8'h0A) begin
        errors++;
        $display("FAIL busy_bytes: %h %h %h %h %h, required 6b 63 f0 ef 0a",
                 txq[s], txq[s + 3], txq[s + 4], txq[s + 35], txq[s + 36]);
      end
    end
  endtask

  task automatic test_resp();
    int k;
    for (int i = 0; i < 16; i++) begin
      rx_send(8'(8'hA0 + i));
      if (i != 15) @(negedge clk);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF) begin
      errors++;
      $display("FAIL resp_full: valid=%b data=%h, required 1 a0a1..af", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF) begin
      errors++;
      $display("FAIL resp_hold: valid=%b data=%h, required 0 a0a1..af", resp_valid, resp_data);
    end
    for (int i = 0; i < 5; i++) rx_send(8'(8'h11 + i));
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (resp_timeout) begin
        k = c;
        break;
      end
    end
    checks++;
    if (k != 101) begin
      errors++;
      $display("FAIL resp_timeout_time: pulse after %0d cycles, required 101", k);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF) begin
      errors++;
      $display("FAIL resp_timeout_keep: valid=%b data=%h, required 0 a0a1..af", resp_valid, resp_data);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) rx_send(8'(8'hB0 + i));
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF) begin
      errors++;
      $display("FAIL resp_after_timeout: valid=%b data=%h, required 1 b0b1..bf", resp_valid, resp_data);
    end
    // A byte arriving in the timeout cycle starts a fresh response.
    for (int i = 0; i < 5; i++) rx_send(8'(8'h21 + i));
    repeat (100) @(negedge clk);
    rx_send(8'hC0);
    checks++;
    if (resp_timeout !== 1'b1) begin
      errors++;
      $display("FAIL resp_collide_timeout: timeout=%b, required 1", resp_timeout);
    end
    for (int i = 1; i < 16; i++) rx_send(8'(8'hC0 + i));
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF) begin
      errors++;
      $display("FAIL resp_collide_data: valid=%b data=%h, required 1 c0c1..cf", resp_valid, resp_data);
    end
  endtask

  task automatic test_reset_abort();
    int s, d0, f0;
    bit ok;
    tx_delay = 5;
    s = txq.size();
    d0 = done_cnt;
    plain_data = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    plain_req = 1'b1;
    @(negedge clk);
    plain_req = 1'b0;
    for (int c = 0; c < 500 && txq.size() - s < 8; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, req_error, tx_flag, resp_valid, resp_timeout} !== 6'b0 ||
        tx_data !== 8'h00 || resp_data !== 128'h0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b flag=%b data=%h resp=%h, required all 0",
               busy, tx_flag, tx_data, resp_data);
    end
    f0 = flag_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if (flag_cnt - f0 !== 0 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abort_quiet: flags=%0d frames=%0d, required 0 0", flag_cnt - f0, done_cnt - d0);
    end
    s = txq.size();
    rst_n = 1'b1;
    plain_req = 1'b1;
    @(negedge clk);
    plain_req = 1'b0;
    checks++;
    if (tx_flag !== 1'b1 || tx_data !== 8'h70) begin
      errors++;
      $display("FAIL abort_restart: flag=%b data=%h, required 1 70", tx_flag, tx_data);
    end
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_done_timeout: frame_done not seen, required within 1000 cycles");
    end
    @(negedge clk);
    checks++;
    if (txq.size() - s !== 22 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL abort_count: bytes=%0d frames=%0d, required 22 1", txq.size() - s, done_cnt - d0);
    end else begin
      checks++;
      if (txq[s + 5] !== 8'h0F || txq[s + 20] !== 8'hF0 || txq[s + 21] !== 8'h0A) begin
        errors++;
        $display("FAIL abort_bytes: %h %h %h, required 0f f0 0a", txq[s + 5], txq[s + 20], txq[s + 21]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_plain();
    test_key();
    test_invalid_and_priority();
    test_busy_drop();
    test_resp();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_frame_tx.md
AES_FRAME_TX -- requirements
Module: aes_frame_tx

Interface
REQ-001 Parameter: PAD_BYTE, 8'h0A, trailing byte appended to every frame; the far-end framer consumes it to assert done.
REQ-002 Parameter: RX_TIMEOUT, 32'd5_000_000, idle clk cycles between response bytes before a partial response is discarded.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 key_req  in  1  one-cycle request to send a key frame.
REQ-006 key_data  in  256  key, MSB-aligned; a 128-bit key occupies [255:128], a 192-bit key occupies [255:64].
REQ-007 key_len  in  2  0=128-bit, 1=192-bit, 2=256-bit, 3=invalid.
REQ-008 plain_req  in  1  one-cycle request to send a plain frame.
REQ-009 plain_data  in  128  block to send.
REQ-010 busy  out  1  frame in progress; requests ignored while high.
REQ-011 frame_done  out  1  one-cycle pulse after the last byte's tx_end.
REQ-012 req_error  out  1  one-cycle pulse on a rejected key request.
REQ-013 tx_data  out  8  byte to the byte transmitter.
REQ-014 tx_flag  out  1  one-cycle strobe: tx_data valid.
REQ-015 tx_end  in  1  one-cycle pulse: transmitter finished the current byte.
REQ-016 rx_data  in  8  received byte from the byte receiver.
REQ-017 rx_flag  in  1  one-cycle strobe: rx_data valid.
REQ-018 resp_data  out  128  last complete 16-byte response; the first byte lands in [127:120].
REQ-019 resp_valid  out  1  one-cycle pulse: resp_data updated.
REQ-020 resp_timeout  out  1  one-cycle pulse: partial response discarded.

Function
REQ-021 Transmit FSM states: IDLE, SEND, WAIT_END, DONE; busy is 1 in every state except IDLE.
REQ-022 In IDLE, key_req takes priority over plain_req when both are asserted in the same cycle; the losing request is dropped.
REQ-023 An accepted request latches data and length; later changes to the inputs have no effect on the frame.
REQ-024 Key frame byte sequence:
- "k", "e", "y";
- mode character: "a" (128-bit), "b" (192-bit) or "c" (256-bit);
- N key bytes (N = 16, 24 or 32), key_data[255:248] first;
- PAD_BYTE.
REQ-025 Key frame total length: 21, 29 or 37 bytes.
REQ-026 Plain frame byte sequence: "p", "l", "a", "i", "n", then 16 bytes with plain_data[127:120] first, then PAD_BYTE; 22 bytes total.
REQ-027 key_req with key_len=3: req_error pulses in the next cycle, no byte is sent, and the FSM stays in IDLE.
REQ-028 IDLE to SEND on acceptance.
REQ-029 SEND:
- asserts tx_flag for exactly one cycle with tx_data valid in that cycle, then moves to WAIT_END;
- the first tx_flag occurs 1 cycle after acceptance.
REQ-030 WAIT_END holds until tx_end.
REQ-031 On tx_end in WAIT_END: go to SEND for the next byte, or to DONE if the byte was the last one; the next tx_flag occurs the cycle after tx_end.
REQ-032 tx_end outside WAIT_END is ignored.
REQ-033 tx_data holds its value until the next tx_flag.
REQ-034 DONE pulses frame_done for one cycle and returns to IDLE; a new request is accepted in the cycle after DONE.
REQ-035 Byte index counter is 6 bits, cleared on acceptance, and never wraps within a frame.
REQ-036 Response collector runs independently of the transmit FSM, concurrent with transmission.
REQ-037 On each rx_flag the collector shifts rx_data into a 128-bit shift register and increments a 5-bit count.
REQ-038 On the 16th byte:
- resp_data is loaded in the cycle after the rx_flag;
- resp_valid pulses in that same cycle;
- the count is cleared.
REQ-039 resp_data holds its value until the next complete response.
REQ-040 Inter-byte timer is cleared on every rx_flag and counts only while the count is nonzero.
REQ-041 When the timer reaches RX_TIMEOUT: resp_timeout pulses, the count and shift register clear, and resp_data is unchanged.
REQ-042 rx_flag in the same cycle as the timeout: the timeout wins, and the incoming byte becomes byte 1 of a new response.

Reset
REQ-043 While rst_n=0, all outputs are held at 0 and the FSM is in IDLE, regardless of clk.
REQ-044 While rst_n=0, the counters, timer, latches and shift register are held at 0.
REQ-045 Reset mid-frame aborts the frame with no further tx_flag, and no frame_done is generated.
REQ-046 The first request is accepted in the first clk edge after rst_n deasserts.

Verification
REQ-047 Plain frame:
- stimulus: plain_req with plain_data=128'h00112233_44556677_8899AABB_CCDDEEFF, transmitter model returns tx_end 20 cycles after each tx_flag;
- response: 22 bytes 70 6C 61 69 6E 00 11 .. FF 0A, then frame_done, busy low.
REQ-048 Key frame:
- stimulus: key_req with key_len=1, key_data=256'h000102...1F;
- response: 6B 65 79 62, bytes 00..17, 0A (29 bytes).
REQ-049 Invalid key and priority:
- key_len=3: req_error pulse with zero tx_flag;
- key_req and plain_req in the same cycle: a key frame is sent and the plain request is dropped.
REQ-050 Busy drop: plain_req during a key frame is ignored; exactly one frame is observed.
REQ-051 Response collection:
- 16 rx bytes 0xA0..0xAF: resp_valid with resp_data=128'hA0A1...AF;
- 5 bytes then silence of RX_TIMEOUT=100 cycles: resp_timeout, resp_data unchanged.
REQ-052 Reset abort: rst_n low after byte 8 of a plain frame gives all outputs 0; a subsequent plain_req restarts the frame from "p".
